// File: rtl/execute_cycle_pkg.sv
// execute_cycle_pkg: shared ALU opcodes, forward-select encodings and datapath width
// for the execute stage.
package execute_cycle_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// alu_unit: single-cycle combinational ALU (add/sub/and/or/slt) with zero flag.
// Any other opcode, including mul, yields zero.
module alu_unit
    import execute_cycle_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      aluControl,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic lessThan;

    always_comb begin
        lessThan = $signed(srcA) < $signed(srcB);
        result   = aluControl == ALU_ADD ? srcA + srcB :
                   aluControl == ALU_SUB ? srcA - srcB :
                   aluControl == ALU_AND ? srcA & srcB :
                   aluControl == ALU_OR  ? srcA | srcB :
                   aluControl == ALU_SLT ? {{(XLEN-1){1'b0}}, lessThan} :
                   '0;
        zero     = result == '0;
    end

endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: execute stage with operand forwarding, branch resolution and E/M register.
// Define EXECUTE_MUL_EN to enable the iterative shift-add multiplier on opcode 110.
module execute_cycle
    import execute_cycle_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Regwrite_E,
    input  logic            ResultSrc_E,
    input  logic            Memwrite_E,
    input  logic            Jump_E,
    input  logic            Branch_E,
    input  logic            AluSrc_E,
    input  logic [2:0]      AluControl_E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic [XLEN-1:0] PCPlus4_E,
    input  logic [XLEN-1:0] Result_W,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [4:0]      Rd_E,
    output logic            Regwrite_M,
    output logic            ResultSrc_M,
    output logic            Memwrite_M,
    output logic [XLEN-1:0] AluResult_M,
    output logic [XLEN-1:0] WriteData_M,
    output logic [XLEN-1:0] PCPlus4_M,
    output logic [4:0]      Rd_M,
    output logic            PCSrc_E,
    output logic [XLEN-1:0] PCTarget_E,
    output logic            Busy_E
);

    logic [XLEN-1:0] srcA, fwdB, srcB, aluResult, exResult, exWriteData;
    logic [XLEN-1:0] product, mulWriteData;
    logic            aluZero, mulDone, zero;

    always_comb begin
        srcA = ForwardA_E == FWD_WB  ? Result_W :
               ForwardA_E == FWD_MEM ? AluResult_M : RD1_E;
        fwdB = ForwardB_E == FWD_WB  ? Result_W :
               ForwardB_E == FWD_MEM ? AluResult_M : RD2_E;
        srcB = AluSrc_E ? Imm_Ext_E : fwdB;
    end

    alu_unit #(.XLEN(XLEN)) u_alu (
        .aluControl(AluControl_E),
        .srcA      (srcA),
        .srcB      (srcB),
        .result    (aluResult),
        .zero      (aluZero)
    );

`ifdef EXECUTE_MUL_EN
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;
    localparam int CW = $clog2(XLEN) + 1;

    logic [1:0]      state;
    logic [XLEN-1:0] mcand, mplier, acc, mulWData;
    logic [CW-1:0]   steps;

    assign Busy_E       = (state == IDLE && AluControl_E == ALU_MUL) || state == BUSY;
    assign mulDone      = state == DONE;
    assign product      = acc;
    assign mulWriteData = mulWData;

    // Operands are frozen at start so forwarding changes mid-multiply cannot corrupt it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            mulWData <= '0;
            steps    <= '0;
        end else begin
            case (state)
                IDLE: if (AluControl_E == ALU_MUL) begin
                    state    <= BUSY;
                    mcand    <= srcA;
                    mplier   <= srcB;
                    mulWData <= fwdB;
                    acc      <= '0;
                    steps    <= '0;
                end
                BUSY: begin
                    acc    <= mplier[0] ? acc + mcand : acc;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    steps  <= steps + CW'(1);
                    state  <= steps == CW'(XLEN - 1) ? DONE : BUSY;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign Busy_E       = 1'b0;
    assign mulDone      = 1'b0;
    assign product      = '0;
    assign mulWriteData = '0;
`endif

    always_comb begin
        exResult    = mulDone ? product : aluResult;
        exWriteData = mulDone ? mulWriteData : fwdB;
        zero        = ~Busy_E & (mulDone ? product == '0 : aluZero);
        PCSrc_E     = Jump_E | (Branch_E & zero);
        PCTarget_E  = PC_E + Imm_Ext_E;
    end

    // A busy stage hands a bubble to memory so nothing is written twice.
    always_ff @(posedge clk) begin
        if (rst || Busy_E) begin
            Regwrite_M  <= 1'b0;
            ResultSrc_M <= 1'b0;
            Memwrite_M  <= 1'b0;
            AluResult_M <= '0;
            WriteData_M <= '0;
            PCPlus4_M   <= '0;
            Rd_M        <= '0;
        end else begin
            Regwrite_M  <= Regwrite_E;
            ResultSrc_M <= ResultSrc_E;
            Memwrite_M  <= Memwrite_E;
            AluResult_M <= exResult;
            WriteData_M <= exWriteData;
            PCPlus4_M   <= PCPlus4_E;
            Rd_M        <= Rd_E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed and randomized checks of execute_cycle against a
// behavioural model; mul checks depend on EXECUTE_MUL_EN.
module tb_execute_cycle;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            Regwrite_E, ResultSrc_E, Memwrite_E, Jump_E, Branch_E, AluSrc_E;
    logic [2:0]      AluControl_E;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E, Result_W;
    logic [1:0]      ForwardA_E, ForwardB_E;
    logic [4:0]      Rd_E;
    logic            Regwrite_M, ResultSrc_M, Memwrite_M, PCSrc_E, Busy_E;
    logic [XLEN-1:0] AluResult_M, WriteData_M, PCPlus4_M, PCTarget_E;
    logic [4:0]      Rd_M;

    int total = 0;
    int bad = 0;
    logic [31:0] mRes = '0;

    always #5 clk = ~clk;

    execute_cycle #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .Regwrite_E(Regwrite_E), .ResultSrc_E(ResultSrc_E), .Memwrite_E(Memwrite_E),
        .Jump_E(Jump_E), .Branch_E(Branch_E), .AluSrc_E(AluSrc_E),
        .AluControl_E(AluControl_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .Result_W(Result_W),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Rd_E(Rd_E),
        .Regwrite_M(Regwrite_M), .ResultSrc_M(ResultSrc_M), .Memwrite_M(Memwrite_M),
        .AluResult_M(AluResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
        .Rd_M(Rd_M), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E), .Busy_E(Busy_E)
    );

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIns();
        {Regwrite_E, ResultSrc_E, Memwrite_E, Jump_E, Branch_E, AluSrc_E} = '0;
        AluControl_E = 3'b000;
        {RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E, Result_W} = '0;
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        Rd_E = '0;
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
        return sel == 2'b01 ? Result_W : sel == 2'b10 ? mRes : rd;
    endfunction

    function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic runOne(input string tag);
        logic [31:0] a, fb, b, res;
        logic [7:0]  ctl;
        a   = fwd(ForwardA_E, RD1_E);
        fb  = fwd(ForwardB_E, RD2_E);
        b   = AluSrc_E ? Imm_Ext_E : fb;
        res = aluModel(AluControl_E, a, b);
        ctl = {Regwrite_E, ResultSrc_E, Memwrite_E, Rd_E};
        #1;
        check({tag, ".pcsrc"}, 32'(PCSrc_E), 32'(Jump_E | (Branch_E & (res == 0))));
        check({tag, ".pctarget"}, PCTarget_E, PC_E + Imm_Ext_E);
        check({tag, ".busy"}, 32'(Busy_E), 32'd0);
        step();
        check({tag, ".result"}, AluResult_M, res);
        check({tag, ".wdata"}, WriteData_M, fb);
        check({tag, ".pc4"}, PCPlus4_M, PCPlus4_E);
        check({tag, ".ctl"}, 32'({Regwrite_M, ResultSrc_M, Memwrite_M, Rd_M}), 32'(ctl));
        mRes = res;
    endtask

`ifdef EXECUTE_MUL_EN
    task automatic mulTest(input string tag, input logic [31:0] a, input logic [31:0] b);
        int busyCycles;
        clearIns();
        AluControl_E = 3'b110;
        RD1_E = a;
        RD2_E = b;
        Regwrite_E = 1'b1;
        Branch_E = 1'b1;
        Rd_E = 5'd9;
        PCPlus4_E = 32'h44;
        busyCycles = 0;
        #1;
        while (Busy_E === 1'b1 && busyCycles < 100) begin
            check({tag, ".zero_held"}, 32'(PCSrc_E), 32'd0);
            busyCycles++;
            step();
            ForwardA_E = 2'b01;
            Result_W = $urandom;
            #1;
            check({tag, ".bubble"}, AluResult_M | 32'({Regwrite_M, Memwrite_M, ResultSrc_M, Rd_M}), 32'd0);
        end
        check({tag, ".busy_cycles"}, 32'(busyCycles), 32'(XLEN + 1));
        step();
        check({tag, ".product"}, AluResult_M, a * b);
        check({tag, ".wdata"}, WriteData_M, b);
        check({tag, ".ctl"}, 32'({Regwrite_M, ResultSrc_M, Memwrite_M, Rd_M}), 32'({3'b100, 5'd9}));
        mRes = a * b;
    endtask
`endif

    initial begin
        logic [2:0] ops [$];
        ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b100, 3'b111};
`ifndef EXECUTE_MUL_EN
        ops.push_back(3'b110);
`endif
        clearIns();
        rst = 1'b1;
        RD1_E = 32'h55;
        RD2_E = 32'h66;
        Regwrite_E = 1'b1;
        Memwrite_E = 1'b1;
        PCPlus4_E = 32'h104;
        Rd_E = 5'd3;
        step();
        step();
        check("reset.result", AluResult_M | WriteData_M | PCPlus4_M, 32'd0);
        check("reset.ctl", 32'({Regwrite_M, ResultSrc_M, Memwrite_M, Rd_M}), 32'd0);
        check("reset.busy", 32'(Busy_E), 32'd0);
        rst = 1'b0;
        mRes = '0;

        clearIns();
        RD1_E = 32'd5;
        Imm_Ext_E = -32'sd3;
        AluSrc_E = 1'b1;
        Regwrite_E = 1'b1;
        Rd_E = 5'd1;
        runOne("add_imm");
        check("add_imm.const", AluResult_M, 32'd2);
        check("add_imm.regwrite", 32'(Regwrite_M), 32'd1);

        clearIns();
        Branch_E = 1'b1;
        AluControl_E = 3'b001;
        RD1_E = 32'd7;
        RD2_E = 32'd7;
        PC_E = 32'h100;
        Imm_Ext_E = 32'h20;
        #1;
        check("branch.pcsrc", 32'(PCSrc_E), 32'd1);
        check("branch.target", PCTarget_E, 32'h120);
        runOne("branch");

        clearIns();
        RD1_E = 32'd4;
        RD2_E = 32'd5;
        runOne("fwd_setup");
        ForwardA_E = 2'b10;
        RD1_E = 32'd1;
        RD2_E = 32'd1;
        runOne("fwd_mem");
        check("fwd_mem.const", AluResult_M, 32'd10);
        ForwardA_E = 2'b01;
        Result_W = 32'd4;
        runOne("fwd_wb");
        check("fwd_wb.const", AluResult_M, 32'd5);
        ForwardA_E = 2'b11;
        runOne("fwd_11");
        check("fwd_11.const", AluResult_M, 32'd2);

        clearIns();
        AluControl_E = 3'b101;
        RD1_E = 32'hFFFF_FFFF;
        RD2_E = 32'd1;
        runOne("slt");
        check("slt.const", AluResult_M, 32'd1);
        AluControl_E = 3'b000;
        RD1_E = 32'h7FFF_FFFF;
        runOne("wrap");
        check("wrap.const", AluResult_M, 32'h8000_0000);

        for (int i = 0; i < 40; i++) begin
            {Regwrite_E, ResultSrc_E, Memwrite_E, Jump_E, Branch_E, AluSrc_E} = 6'($urandom);
            AluControl_E = ops[$urandom_range(0, ops.size() - 1)];
            RD1_E = $urandom;
            RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
            Imm_Ext_E = $urandom;
            PC_E = $urandom;
            PCPlus4_E = $urandom;
            Result_W = $urandom;
            ForwardA_E = 2'($urandom);
            ForwardB_E = 2'($urandom);
            Rd_E = 5'($urandom);
            runOne("rand");
        end

`ifdef EXECUTE_MUL_EN
        mulTest("mul_6x7", 32'd6, 32'd7);
        check("mul_6x7.const", AluResult_M, 32'd42);
        mulTest("mul_max", 32'hFFFF_FFFF, 32'd2);
        check("mul_max.const", AluResult_M, 32'hFFFF_FFFE);

        clearIns();
        AluControl_E = 3'b110;
        RD1_E = 32'd3;
        RD2_E = 32'd5;
        Regwrite_E = 1'b1;
        Rd_E = 5'd7;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        AluControl_E = 3'b000;
        RD1_E = 32'd1;
        RD2_E = 32'd1;
        Rd_E = 5'd2;
        step();
        rst = 1'b0;
        check("mulrst.result", AluResult_M | WriteData_M | PCPlus4_M, 32'd0);
        check("mulrst.ctl", 32'({Regwrite_M, ResultSrc_M, Memwrite_M, Rd_M}), 32'd0);
        check("mulrst.busy", 32'(Busy_E), 32'd0);
        mRes = '0;
        for (int i = 0; i < 4; i++) runOne("post_rst");
        check("post_rst.const", AluResult_M, 32'd2);
`else
        clearIns();
        AluControl_E = 3'b110;
        RD1_E = 32'd6;
        RD2_E = 32'd7;
        Regwrite_E = 1'b1;
        Rd_E = 5'd9;
        runOne("mul_off");
        check("mul_off.const", AluResult_M, 32'd0);
        check("mul_off.regwrite", 32'(Regwrite_M), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
